// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port RAM with byte enables, power-on clear sweep,
// selectable read-during-write behaviour and same-address write collision flag.
module dual_port_ram_be #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 3,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_a,
    input  logic                wr_en_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   data_in_a,
    output logic [DATA_W-1:0]   data_out_a,
    output logic                valid_a,
    input  logic                en_b,
    input  logic                wr_en_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_in_b,
    output logic [DATA_W-1:0]   data_out_b,
    output logic                valid_b,
    output logic                init_busy,
    output logic                collision
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                acc_a, acc_b, wr_a, wr_b, same;
    logic [DATA_W-1:0]   new_a, new_b;

    assign init_busy = (state == CLEAR);
    assign acc_a = (state == READY) & en_a;
    assign acc_b = (state == READY) & en_b;
    assign wr_a = acc_a & wr_en_a;
    assign wr_b = acc_b & wr_en_b;
    assign same = (addr_a == addr_b);

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == LAST)
            state_next = READY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && clr_ptr != LAST)
                clr_ptr <= clr_ptr + ADDR_W'(1);
        end
    end

    // B's lane writes come last so B wins overlapping bytes on the same word
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            for (int i = 0; i < NB; i++) begin
                if (wr_a && be_a[i])
                    mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
                if (wr_b && be_b[i])
                    mem[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
            end
        end
    end

    // Post-write view of each port's word, including the other port's write
    always_comb begin
        new_a = '0;
        new_b = '0;
        for (int i = 0; i < NB; i++) begin
            new_a[8*i +: 8] = (wr_b && be_b[i] && same) ? data_in_b[8*i +: 8] :
                              (wr_a && be_a[i])         ? data_in_a[8*i +: 8] :
                                                          mem[addr_a][8*i +: 8];
            new_b[8*i +: 8] = (wr_b && be_b[i])         ? data_in_b[8*i +: 8] :
                              (wr_a && be_a[i] && same) ? data_in_a[8*i +: 8] :
                                                          mem[addr_b][8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_a <= '0;
            data_out_b <= '0;
            valid_a    <= 1'b0;
            valid_b    <= 1'b0;
            collision  <= 1'b0;
        end else begin
            valid_a   <= acc_a;
            valid_b   <= acc_b;
            collision <= wr_a & wr_b & same & (|(be_a & be_b));
            if (acc_a)
                data_out_a <= (RDW_MODE != 0) ? new_a : mem[addr_a];
            if (acc_b)
                data_out_b <= (RDW_MODE != 0) ? new_b : mem[addr_b];
        end
    end
endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be: drives read-first and write-first instances with shared
// stimulus and checks both against a whole-word byte-merging reference model.
module tb_dual_port_ram_be;
    localparam int DW = 128;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk, rst;
    logic          en_a, wr_en_a, en_b, wr_en_b;
    logic [15:0]   be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_in_a, data_in_b;
    logic [DW-1:0] oa0, ob0, oa1, ob1;
    logic          va0, vb0, va1, vb1, busy0, busy1, col0, col1;

    int n_vec = 0;
    int n_err = 0;

    dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .wr_en_a(wr_en_a), .be_a(be_a), .addr_a(addr_a),
        .data_in_a(data_in_a), .data_out_a(oa0), .valid_a(va0),
        .en_b(en_b), .wr_en_b(wr_en_b), .be_b(be_b), .addr_b(addr_b),
        .data_in_b(data_in_b), .data_out_b(ob0), .valid_b(vb0),
        .init_busy(busy0), .collision(col0)
    );

    dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .wr_en_a(wr_en_a), .be_a(be_a), .addr_a(addr_a),
        .data_in_a(data_in_a), .data_out_a(oa1), .valid_a(va1),
        .en_b(en_b), .wr_en_b(wr_en_b), .be_b(be_b), .addr_b(addr_b),
        .data_in_b(data_in_b), .data_out_b(ob1), .valid_b(vb1),
        .init_busy(busy1), .collision(col1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bmask(input logic [15:0] be);
        logic [DW-1:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Reference model: a word array; writes applied A then B as whole masked words
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] ea0, ea1, eb0, eb1, pa, pb;
    logic          eva, evb, ecol, known = 1'b0;
    int            busy_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            known = 1'b1;
            busy_left = DEPTH;
            for (int w = 0; w < DEPTH; w++) mm[w] = '0;
            ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0;
            eva = 1'b0; evb = 1'b0; ecol = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            eva = 1'b0; evb = 1'b0; ecol = 1'b0;
        end else begin
            pa = mm[addr_a];
            pb = mm[addr_b];
            if (en_a && wr_en_a)
                mm[addr_a] = (mm[addr_a] & ~bmask(be_a)) | (data_in_a & bmask(be_a));
            if (en_b && wr_en_b)
                mm[addr_b] = (mm[addr_b] & ~bmask(be_b)) | (data_in_b & bmask(be_b));
            ecol = en_a && wr_en_a && en_b && wr_en_b && addr_a == addr_b && (be_a & be_b) != 0;
            if (en_a) begin ea0 = pa; ea1 = mm[addr_a]; end
            if (en_b) begin eb0 = pb; eb1 = mm[addr_b]; end
            eva = en_a;
            evb = en_b;
        end
    end

    always @(negedge clk) begin
        if (known) begin
            chk("m0_dout_a", oa0, ea0);
            chk("m0_dout_b", ob0, eb0);
            chk("m1_dout_a", oa1, ea1);
            chk("m1_dout_b", ob1, eb1);
            chk("m0_valid_a", DW'(va0), DW'(eva));
            chk("m0_valid_b", DW'(vb0), DW'(evb));
            chk("m1_valid_a", DW'(va1), DW'(eva));
            chk("m1_valid_b", DW'(vb1), DW'(evb));
            chk("m0_collision", DW'(col0), DW'(ecol));
            chk("m1_collision", DW'(col1), DW'(ecol));
            chk("m0_init_busy", DW'(busy0), DW'(busy_left > 0));
            chk("m1_init_busy", DW'(busy1), DW'(busy_left > 0));
        end
    end

    task automatic idle();
        en_a = 0; wr_en_a = 0; be_a = '0; addr_a = '0; data_in_a = '0;
        en_b = 0; wr_en_b = 0; be_b = '0; addr_b = '0; data_in_b = '0;
    endtask

    task automatic busy_len(input string nm, input bit poke_a);
        int cnt = 0;
        while (busy0 && cnt < 20) begin
            @(negedge clk);
            if (poke_a) chk({nm, "_valid_a_in_clear"}, DW'(va0), '0);
            cnt++;
        end
        chk(nm, DW'(cnt), DW'(DEPTH));
    endtask

    initial begin
        logic [DW-1:0] ones11;
        ones11 = {16{8'h11}};
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", DW'(busy0), DW'(1));
        chk("rst_dout_a", oa0, '0);
        chk("rst_valid_a", DW'(va0), '0);
        chk("rst_collision", DW'(col1), '0);
        busy_len("clear_len", 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1; addr_a = AW'(i); en_b = 1; addr_b = AW'(7 - i);
            @(negedge clk);
            chk("clr_read_a", oa1, '0);
            chk("clr_valid_a", DW'(va1), DW'(1));
        end
        idle();

        en_a = 1; wr_en_a = 1; be_a = 16'hFFFF; addr_a = 2; data_in_a = ones11;
        @(negedge clk);
        be_a = 16'h0001; data_in_a = DW'(8'hFF);
        @(negedge clk);
        chk("be_wr_m0", oa0, ones11);
        chk("be_wr_m1", oa1, {{15{8'h11}}, 8'hFF});
        idle(); en_b = 1; addr_b = 2;
        @(negedge clk);
        chk("be_read_b", ob0, {{15{8'h11}}, 8'hFF});

        idle();
        en_a = 1; wr_en_a = 1; be_a = 16'h0003; addr_a = 5; data_in_a = DW'(16'hAAAA);
        en_b = 1; wr_en_b = 1; be_b = 16'h0002; addr_b = 5; data_in_b = DW'(16'hBBBB);
        @(negedge clk);
        chk("coll_pulse", DW'(col0), DW'(1));
        idle(); en_a = 1; addr_a = 5;
        @(negedge clk);
        chk("coll_drop", DW'(col0), '0);
        chk("coll_merge", oa0, DW'(16'hBBAA));

        idle();
        en_a = 1; wr_en_a = 1; be_a = 16'hFFFF; addr_a = 1; data_in_a = DW'(5);
        @(negedge clk);
        data_in_a = DW'(9); en_b = 1; addr_b = 1;
        @(negedge clk);
        chk("rdw_b_m0", ob0, DW'(5));
        chk("rdw_b_m1", ob1, DW'(9));
        chk("rdw_a_m0", oa0, DW'(5));
        chk("rdw_a_m1", oa1, DW'(9));

        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en_a = 1; addr_a = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midclr_valid_a", DW'(va0), '0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busy_len("midclr_len", 1'b1);
        idle();

        for (int c = 0; c < 10000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            en_a = $urandom_range(0, 3) != 0;
            en_b = $urandom_range(0, 3) != 0;
            wr_en_a = $urandom_range(0, 1) != 0;
            wr_en_b = $urandom_range(0, 1) != 0;
            be_a = ($urandom_range(0, 7) == 0) ? 16'h0 : ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            be_b = ($urandom_range(0, 7) == 0) ? 16'h0 : ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            addr_a = AW'($urandom);
            addr_b = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom);
            data_in_a = {$urandom, $urandom, $urandom, $urandom};
            data_in_b = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        idle(); rst = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
